pio_pc_bank: RTL and testbench



---
 rtl/pio_pkg.sv | 18 +
 rtl/pio_pc_channel.sv | 94 +++++++++
 rtl/pio_pc_bank.sv | 46 ++++
 tb/tb_pio_pc_bank.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared PIO definitions: address type, counter width,
// and the per-edge PC update kinds.
package pio_pkg;

   localparam int PIO_ADDR_W     = 5;
   localparam int PIO_WRAP_CNT_W = 8;

   typedef logic [PIO_ADDR_W-1:0] pio_addr_t;

   typedef enum logic [2:0] {
      PC_RESTART,
      PC_JUMP,
      PC_WRAP,
      PC_INC,
      PC_HOLD
   } pc_upd_e;

endpackage

// File: rtl/pio_pc_channel.sv
// One PIO program counter with wrap window, jump, stall, restart.
// Optional wrap counter when PIO_PC_WRAP_CNT_EN is defined.
module pio_pc_channel
   import pio_pkg::*;
#(
   parameter int ADDR_W = PIO_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] wrap_top,
   input  logic [ADDR_W-1:0] wrap_bottom,
   input  logic              wrap_en,
   input  logic [ADDR_W-1:0] jump,
   input  logic              jump_en,
   input  logic              pc_en,
   input  logic              restart,
`ifdef PIO_PC_WRAP_CNT_EN
   output logic [PIO_WRAP_CNT_W-1:0] wrap_cnt,
`endif
   output logic [ADDR_W-1:0] pc,
   output logic              wrapped
);

   pc_upd_e           upd;
   logic [ADDR_W-1:0] pc_d, pc_q;
   logic              wrapped_d, wrapped_q;

   // Pick the highest-priority update for this edge.
   always_comb begin
      upd = PC_HOLD;
      if (restart)
         upd = PC_RESTART;
      else if (pc_en && jump_en)
         upd = PC_JUMP;
      else if (pc_en && wrap_en && (pc_q == wrap_bottom))
         upd = PC_WRAP;
      else if (pc_en)
         upd = PC_INC;
   end

   // Next PC and wrap pulse from the chosen update.
   always_comb begin
      pc_d      = pc_q;
      wrapped_d = 1'b0;
      unique case (upd)
         PC_RESTART: pc_d = wrap_top;
         PC_JUMP:    pc_d = jump;
         PC_WRAP: begin
            pc_d      = wrap_top;
            wrapped_d = 1'b1;
         end
         PC_INC:     pc_d = pc_q + ADDR_W'(1);
         default:    pc_d = pc_q;
      endcase
   end

   // PC and wrap-pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= '0;
         wrapped_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign pc      = pc_q;
   assign wrapped = wrapped_q;

`ifdef PIO_PC_WRAP_CNT_EN
   logic [PIO_WRAP_CNT_W-1:0] cnt_d, cnt_q;

   // Saturating wrap count; restart clears it even on a wrap edge.
   always_comb begin
      cnt_d = cnt_q;
      if (upd == PC_RESTART)
         cnt_d = '0;
      else if ((upd == PC_WRAP) && (cnt_q != '1))
         cnt_d = cnt_q + PIO_WRAP_CNT_W'(1);
   end

   // Wrap counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign wrap_cnt = cnt_q;
`endif

endmodule

// File: rtl/pio_pc_bank.sv
// Bank of independent PIO program counters, one per state machine.
// Optional output wrap_cnt when PIO_PC_WRAP_CNT_EN is defined.
module pio_pc_bank
   import pio_pkg::*;
#(
   parameter int NUM_SM = 4,
   parameter int ADDR_W = PIO_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_SM*ADDR_W-1:0] wrap_top,
   input  logic [NUM_SM*ADDR_W-1:0] wrap_bottom,
   input  logic [NUM_SM-1:0]        wrap_en,
   input  logic [NUM_SM*ADDR_W-1:0] jump,
   input  logic [NUM_SM-1:0]        jump_en,
   input  logic [NUM_SM-1:0]        pc_en,
   input  logic [NUM_SM-1:0]        restart,
`ifdef PIO_PC_WRAP_CNT_EN
   output logic [NUM_SM*PIO_WRAP_CNT_W-1:0] wrap_cnt,
`endif
   output logic [NUM_SM*ADDR_W-1:0] pc,
   output logic [NUM_SM-1:0]        wrapped
);

   for (genvar i = 0; i < NUM_SM; i++) begin : g_ch
      pio_pc_channel #(
         .ADDR_W(ADDR_W)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .wrap_top   (wrap_top[i*ADDR_W +: ADDR_W]),
         .wrap_bottom(wrap_bottom[i*ADDR_W +: ADDR_W]),
         .wrap_en    (wrap_en[i]),
         .jump       (jump[i*ADDR_W +: ADDR_W]),
         .jump_en    (jump_en[i]),
         .pc_en      (pc_en[i]),
         .restart    (restart[i]),
`ifdef PIO_PC_WRAP_CNT_EN
         .wrap_cnt   (wrap_cnt[i*PIO_WRAP_CNT_W +: PIO_WRAP_CNT_W]),
`endif
         .pc         (pc[i*ADDR_W +: ADDR_W]),
         .wrapped    (wrapped[i])
      );
   end

endmodule

// File: tb/tb_pio_pc_bank.sv
// Self-checking bench for pio_pc_bank: reference model plus
// directed scenarios with literal expectations.
module tb_pio_pc_bank;

   localparam int NUM_SM = 4;
   localparam int ADDR_W = 5;
   localparam int SPAN   = 1 << ADDR_W;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NUM_SM*ADDR_W-1:0] wrap_top = '0;
   logic [NUM_SM*ADDR_W-1:0] wrap_bottom = '0;
   logic [NUM_SM-1:0]        wrap_en = '0;
   logic [NUM_SM*ADDR_W-1:0] jump = '0;
   logic [NUM_SM-1:0]        jump_en = '0;
   logic [NUM_SM-1:0]        pc_en = '0;
   logic [NUM_SM-1:0]        restart = '0;
   logic [NUM_SM*ADDR_W-1:0] pc;
   logic [NUM_SM-1:0]        wrapped;
`ifdef PIO_PC_WRAP_CNT_EN
   logic [NUM_SM*8-1:0]      wrap_cnt;
`endif

   int checks = 0;
   int errors = 0;

   int mpc [NUM_SM];
   int mw  [NUM_SM];
   int mcnt[NUM_SM];

   pio_pc_bank #(
      .NUM_SM(NUM_SM),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrap_top   (wrap_top),
      .wrap_bottom(wrap_bottom),
      .wrap_en    (wrap_en),
      .jump       (jump),
      .jump_en    (jump_en),
      .pc_en      (pc_en),
      .restart    (restart),
`ifdef PIO_PC_WRAP_CNT_EN
      .wrap_cnt   (wrap_cnt),
`endif
      .pc         (pc),
      .wrapped    (wrapped)
   );

   always #5 clk = ~clk;

   // Reference model: integer PCs following the update rules.
   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < NUM_SM; i++) begin
         int top, bot, jmp;
         top = int'(wrap_top[i*ADDR_W +: ADDR_W]);
         bot = int'(wrap_bottom[i*ADDR_W +: ADDR_W]);
         jmp = int'(jump[i*ADDR_W +: ADDR_W]);
         if (!rst_n) begin
            mpc[i] = 0; mw[i] = 0; mcnt[i] = 0;
         end else if (restart[i]) begin
            mpc[i] = top; mw[i] = 0; mcnt[i] = 0;
         end else if (pc_en[i] && jump_en[i]) begin
            mpc[i] = jmp; mw[i] = 0;
         end else if (pc_en[i] && wrap_en[i] && mpc[i] == bot) begin
            mpc[i] = top; mw[i] = 1;
            if (mcnt[i] < 255) mcnt[i] = mcnt[i] + 1;
         end else if (pc_en[i]) begin
            mpc[i] = (mpc[i] + 1) % SPAN; mw[i] = 0;
         end else begin
            mw[i] = 0;
         end
      end
   end

   // Every falling edge: DUT against model, all channels.
   always @(negedge clk) begin
      for (int i = 0; i < NUM_SM; i++) begin
         int apc, aw;
         apc = int'(pc[i*ADDR_W +: ADDR_W]);
         aw  = int'(wrapped[i]);
         checks++;
         if (apc != mpc[i] || aw != mw[i]) begin
            errors++;
            $display("FAIL model ch%0d: pc=%0d wrapped=%0d, want pc=%0d wrapped=%0d",
                     i, apc, aw, mpc[i], mw[i]);
         end
`ifdef PIO_PC_WRAP_CNT_EN
         checks++;
         if (int'(wrap_cnt[i*8 +: 8]) != mcnt[i]) begin
            errors++;
            $display("FAIL model_cnt ch%0d: cnt=%0d want %0d",
                     i, wrap_cnt[i*8 +: 8], mcnt[i]);
         end
`endif
      end
   end

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic expect_ch(input int ch, input int epc, input int ew,
                            input string name);
      int apc, aw;
      apc = int'(pc[ch*ADDR_W +: ADDR_W]);
      aw  = int'(wrapped[ch]);
      checks++;
      if (apc != epc || aw != ew) begin
         errors++;
         $display("FAIL %s ch%0d: pc=%0d wrapped=%0d, want pc=%0d wrapped=%0d",
                  name, ch, apc, aw, epc, ew);
      end
   endtask

   task automatic cfg(input int ch, input int top, input int bot,
                      input int jmp);
      wrap_top[ch*ADDR_W +: ADDR_W]    = ADDR_W'(top);
      wrap_bottom[ch*ADDR_W +: ADDR_W] = ADDR_W'(bot);
      jump[ch*ADDR_W +: ADDR_W]        = ADDR_W'(jmp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      for (int i = 0; i < NUM_SM; i++) expect_ch(i, 0, 0, "reset");
      @(negedge clk);
      rst_n = 1'b1;

      // ch1 free-runs throughout, checked by the model
      pc_en[1] = 1'b1;

      // Wrap window 4..7 on ch0
      cfg(0, 4, 7, 20);
      wrap_en[0] = 1'b1; pc_en[0] = 1'b1; restart[0] = 1'b1;
      tick(); restart[0] = 1'b0;
      expect_ch(0, 4, 0, "restart");
      tick(); expect_ch(0, 5, 0, "wrap_inc5");
      tick(); expect_ch(0, 6, 0, "wrap_inc6");
      tick(); expect_ch(0, 7, 0, "wrap_inc7");
      tick(); expect_ch(0, 4, 1, "wrap_to4");
      tick(); expect_ch(0, 5, 0, "wrap_pulse_end");
      tick(2); expect_ch(0, 7, 0, "at_bottom");

      // Jump beats wrap; restart beats jump
      jump_en[0] = 1'b1;
      tick(); expect_ch(0, 20, 0, "jump_over_wrap");
      jump_en[0] = 1'b0;
      tick(); expect_ch(0, 21, 0, "outside_window_inc");
      jump[0 +: ADDR_W] = ADDR_W'(7);
      jump_en[0] = 1'b1;
      tick(); expect_ch(0, 7, 0, "jump_back7");
      jump[0 +: ADDR_W] = ADDR_W'(20);
      restart[0] = 1'b1;
      tick(); expect_ch(0, 4, 0, "restart_over_jump");
      restart[0] = 1'b0;

      // Stall with jump_en held: nothing happens
      pc_en[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick(); expect_ch(0, 4, 0, "stall");
      end
      jump_en[0] = 1'b0;

      // Async reset mid-run with ch2 at 13
      cfg(2, 0, 0, 13);
      pc_en[2] = 1'b1; jump_en[2] = 1'b1;
      tick(); jump_en[2] = 1'b0;
      expect_ch(2, 13, 0, "pre_reset13");
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < NUM_SM; i++) expect_ch(i, 0, 0, "async_reset");
      for (int k = 0; k < 3; k++) begin
         tick(); expect_ch(2, 0, 0, "reset_hold");
      end
      rst_n = 1'b1;
      tick(); expect_ch(2, 1, 0, "post_reset_inc");

      // Inverted window 30..1 on ch3, then address-space rollover
      cfg(3, 30, 1, 0);
      wrap_en[3] = 1'b1; pc_en[3] = 1'b1; restart[3] = 1'b1;
      tick(); restart[3] = 1'b0;
      expect_ch(3, 30, 0, "inv_restart");
      tick(); expect_ch(3, 31, 0, "inv_31");
      tick(); expect_ch(3, 0, 0, "inv_roll0");
      tick(); expect_ch(3, 1, 0, "inv_1");
      tick(); expect_ch(3, 30, 1, "inv_wrap30");
      tick(); expect_ch(3, 31, 0, "inv_31b");
      wrap_en[3] = 1'b0;
      tick(); expect_ch(3, 0, 0, "free_roll0");
      tick(); expect_ch(3, 1, 0, "free_past_bottom");
      tick(); expect_ch(3, 2, 0, "free_2");

      // top == bottom: every advance wraps to the same address
      cfg(1, 9, 9, 0);
      wrap_en[1] = 1'b1; restart[1] = 1'b1;
      tick(); restart[1] = 1'b0;
      expect_ch(1, 9, 0, "same_restart");
      for (int k = 0; k < 3; k++) begin
         tick(); expect_ch(1, 9, 1, "same_wrap");
      end

`ifdef PIO_PC_WRAP_CNT_EN
      // Saturating wrap counter on ch0, cleared by restart
      cfg(0, 3, 3, 0);
      pc_en[0] = 1'b1; restart[0] = 1'b1;
      tick(); restart[0] = 1'b0;
      tick(300);
      checks++;
      if (wrap_cnt[7:0] != 8'hFF) begin
         errors++;
         $display("FAIL cnt_sat: cnt=%0d want 255", wrap_cnt[7:0]);
      end
      restart[0] = 1'b1;
      tick(); restart[0] = 1'b0;
      checks++;
      if (wrap_cnt[7:0] != 8'h00) begin
         errors++;
         $display("FAIL cnt_clear: cnt=%0d want 0", wrap_cnt[7:0]);
      end
`endif

      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
